d_write_buffer: RTL
===================

Name: d_write_buffer

Overview:
- Posted write buffer between the data cache's memory-side SRAM-like port and the SRAM-like-to-AXI bridge.
- Accepts dirty-line writebacks (single word, sized) from the cache, acknowledges them immediately and drains them to memory in FIFO order.
- Read misses go to memory only after all older buffered writes have drained, which preserves RAW ordering.
- One downstream transaction is outstanding at a time.

Parameters:
- DEPTH, 4, number of buffered write entries; power of two, ≥2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- up_req  in  1  request from cache; deasserted by cache after up_addr_ok.
- up_wr  in  1  1=write, 0=read.
- up_size  in  2  00 byte, 01 half, 10 word.
- up_addr  in  AW  byte address.
- up_wdata  in  DW  write data.
- up_rdata  out  DW  read data, valid with up_data_ok.
- up_addr_ok  out  1  request accepted this cycle.
- up_data_ok  out  1  one-cycle completion pulse.
- mem_req  out  1  downstream request.
- mem_wr  out  1  downstream write flag.
- mem_size  out  2  downstream size.
- mem_addr  out  AW  downstream address.
- mem_wdata  out  DW  downstream write data.
- mem_rdata  in  DW  downstream read data.
- mem_addr_ok  in  1  downstream address accepted.
- mem_data_ok  in  1  downstream completion.
- wb_empty  out  1  FIFO empty and no downstream write in flight.

Behaviour:
- Reset values (asynchronous): FIFO cleared (head = tail = 0, count = 0), state IDLE, all outputs 0, wb_empty = 1, up_rdata = 0.
- Write accept: when up_req & up_wr & count<DEPTH:
  - up_addr_ok = 1 combinationally in that cycle.
  - {addr, size, wdata} is pushed at the next edge.
  - up_data_ok pulses exactly one cycle later from a register.
- Write accept when full: up_addr_ok = 0 and the cache holds the request.
- Count width is clog2(DEPTH)+1. Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Push and pop in the same cycle leave count unchanged. When full, push and pop in the same cycle is allowed (the entry is freed by the pop in the same edge).
- Downstream FSM states: IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA.
- From IDLE:
  - If count>0, go to W_ADDR. Drain has priority over reads.
  - Otherwise, if up_req & ~up_wr, go to R_ADDR. The read request is latched into rd_addr/rd_size.
- W_ADDR:
  - mem_req = 1, mem_wr = 1; mem_addr, mem_size and mem_wdata come from the FIFO head.
  - On mem_addr_ok, go to W_DATA.
- W_DATA:
  - mem_req = 0.
  - On mem_data_ok, pop the head and go to IDLE.
- R_ADDR:
  - mem_req = 1, mem_wr = 0, using the latched address and size.
  - up_addr_ok = mem_addr_ok, passed through in the same cycle.
  - On mem_addr_ok, go to R_DATA.
- R_DATA:
  - up_data_ok = mem_data_ok and up_rdata = mem_rdata, both combinational.
  - On mem_data_ok, go to IDLE.
- Read issued while the FIFO is non-empty: no up_addr_ok until the FIFO has drained and R_ADDR is reached. Reads never overtake writes.
- Writes arriving during R_ADDR/R_DATA/W_*: accepted if not full. They do not affect the in-flight transaction.
- While a read is in flight, a second read is not accepted (up_addr_ok = 0).
- Minimum latency:
  - Write to up_data_ok: 1 cycle.
  - Write to memory: 1 cycle after push if IDLE.
  - Read with FIFO empty: mem_req in the cycle after up_req.
- wb_empty = (count==0) & state∉{W_ADDR, W_DATA}.
- Reset mid-transaction abandons the downstream transaction. The bridge is reset by the same rst.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - A read whose word address matches a buffered entry with size 10 is served from the youngest matching entry.
  - up_addr_ok is asserted in the request cycle; up_data_ok and up_rdata come registered one cycle later.
  - No downstream access occurs and drain continues undisturbed.
  - A match on any entry with size≠10 falls back to drain-then-read.
- Undefined: all reads wait for drain, as above. No match logic is synthesised.

Decomposition:
- Package dcache_bus_pkg holds:
  - the state enum;
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the entry struct {addr, size, wdata}.
- Sub-module wb_fifo:
  - DEPTH-entry circular buffer with push/pop, head output, full/empty/count.
  - A parallel match port that exists only under WB_FWD_EN.

Test Plan:
- Single write, addr 0x1000_0004, data 0xDEAD_BEEF, size 10, mem_addr_ok/mem_data_ok after 2 cycles:
  - up_addr_ok is asserted in the same cycle and up_data_ok one cycle later.
  - mem sees req/wr=1, addr 0x1000_0004, wdata 0xDEAD_BEEF.
  - wb_empty returns to 1 after mem_data_ok.
- Five back-to-back writes with mem_addr_ok held 0:
  - The first four are accepted.
  - The fifth stalls with up_addr_ok = 0 until the first pop.
  - Memory receives all five in order. Pointer wrap is checked.
- Write 0x2000_0000←0x1111_1111 followed immediately by a read of 0x2000_0000 (no forwarding):
  - mem_req for the read appears only after the write's mem_data_ok.
  - up_rdata equals mem_rdata and is returned with up_data_ok.
- Read with the FIFO empty, memory latency 3: up_data_ok pulses exactly on mem_data_ok with the matching data, and no writes are issued.
- With WB_FWD_EN, write 0x3000_0008←0xCAFE_0001 then 0x3000_0008←0xCAFE_0002, memory stalled, then read 0x3000_0008:
  - up_data_ok arrives next cycle with 0xCAFE_0002 and no downstream read.
  - A byte write to the same word forces the drain path instead.
- Assert rst asynchronously while in W_DATA with 3 entries buffered:
  - Outputs drop without waiting for a clock edge, and wb_empty = 1.
  - After release, the next write proceeds normally.

Source files
------------

// File: rtl/dcache_bus_pkg.sv
// Shared types for the data-cache memory-side bus and its write buffer.
// Holds the buffer FSM states, size encodings and the buffered entry layout.
package dcache_bus_pkg;

   localparam int WB_AW = 32;
   localparam int WB_DW = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_ADDR,
      ST_W_DATA,
      ST_R_ADDR,
      ST_R_DATA
   } wb_state_t;

   typedef struct packed {
      logic [WB_AW-1:0] addr;
      logic [1:0]       size;
      logic [WB_DW-1:0] wdata;
   } wb_entry_t;

   function automatic logic is_word(input logic [1:0] sz);
      return sz == SZ_WORD;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of posted writes: push at tail, pop at head, occupancy count.
// Ports: i_push/i_pop/i_din in, o_head/o_count/o_full/o_empty out.
// With WB_FWD_EN defined: i_match_word in, o_fwd/o_fwd_data out
// (youngest word-sized match, suppressed if any matching entry is partial).
module wb_fifo
   import dcache_bus_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  wb_entry_t        i_din,
   output wb_entry_t        o_head,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty
`ifdef WB_FWD_EN
   ,
   input  logic [WB_AW-1:2] i_match_word,
   output logic             o_fwd,
   output logic [WB_DW-1:0] o_fwd_data
`endif
);

   wb_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_tail <= r_tail + 1'b1;
         if (i_pop)  r_head <= r_head + 1'b1;
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   // Storage needs no reset: only slots inside [head, head+count) are read.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_tail] <= i_din;
   end

   assign o_head  = r_mem[r_head];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

`ifdef WB_FWD_EN
   logic w_hit;
   logic w_part;

   // Walk oldest to youngest so the last hit carries the youngest data.
   always_comb begin
      w_hit      = 1'b0;
      w_part     = 1'b0;
      o_fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < r_count) &&
             (r_mem[r_head + PW'(i)].addr[WB_AW-1:2] == i_match_word)) begin
            w_hit      = 1'b1;
            o_fwd_data = r_mem[r_head + PW'(i)].wdata;
            if (!is_word(r_mem[r_head + PW'(i)].size)) w_part = 1'b1;
         end
      end
   end

   assign o_fwd = w_hit & ~w_part;
`endif

endmodule

// File: rtl/d_write_buffer.sv
// Posted write buffer between the D-cache memory port and the AXI bridge.
// Ports: up_* cache side, mem_* bridge side, wb_empty = nothing left to drain.
// Optional WB_FWD_EN: serve reads hitting buffered full-word writes locally.
module d_write_buffer
   import dcache_bus_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = WB_AW,
   parameter int DW    = WB_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_req,
   input  logic          up_wr,
   input  logic [1:0]    up_size,
   input  logic [AW-1:0] up_addr,
   input  logic [DW-1:0] up_wdata,
   output logic [DW-1:0] up_rdata,
   output logic          up_addr_ok,
   output logic          up_data_ok,
   output logic          mem_req,
   output logic          mem_wr,
   output logic [1:0]    mem_size,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_addr_ok,
   input  logic          mem_data_ok,
   output logic          wb_empty
);

   localparam int CW = $clog2(DEPTH) + 1;

   wb_state_t     r_state;
   wb_state_t     w_state_nxt;
   logic [AW-1:0] r_rd_addr;
   logic [1:0]    r_rd_size;
   logic          r_data_ok;

   wb_entry_t     w_din;
   wb_entry_t     w_head;
   logic [CW-1:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_rd_lat;
   logic          w_fwd;
   logic          w_st_wa;
   logic          w_st_wd;
   logic          w_st_ra;
   logic          w_st_rd;

   assign w_st_wa = (r_state == ST_W_ADDR);
   assign w_st_wd = (r_state == ST_W_DATA);
   assign w_st_ra = (r_state == ST_R_ADDR);
   assign w_st_rd = (r_state == ST_R_DATA);

   assign w_pop  = w_st_wd & mem_data_ok;
   // A full buffer still takes a write when the head retires this edge.
   assign w_push = up_req & up_wr & (~w_full | w_pop);

   assign w_din.addr  = up_addr;
   assign w_din.size  = up_size;
   assign w_din.wdata = up_wdata;

`ifdef WB_FWD_EN
   logic          w_hit;
   logic [DW-1:0] w_fwd_data;
   logic [DW-1:0] r_rdata;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_push),
      .i_pop        (w_pop),
      .i_din        (w_din),
      .o_head       (w_head),
      .o_count      (w_count),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .i_match_word (up_addr[AW-1:2]),
      .o_fwd        (w_hit),
      .o_fwd_data   (w_fwd_data)
   );

   // A read already owning the downstream port must finish first.
   assign w_fwd = up_req & ~up_wr & w_hit & ~w_st_ra & ~w_st_rd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_rdata <= '0;
      else if (w_fwd) r_rdata <= w_fwd_data;
   end

   assign up_rdata = w_st_rd ? mem_rdata : r_rdata;
`else
   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_din),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_fwd    = 1'b0;
   assign up_rdata = w_st_rd ? mem_rdata : '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_rd_addr <= '0;
         r_rd_size <= '0;
         r_data_ok <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_data_ok <= w_push | w_fwd;
         if (w_rd_lat) begin
            r_rd_addr <= up_addr;
            r_rd_size <= up_size;
         end
      end
   end

   // Draining always wins over a waiting read, keeping RAW order.
   always_comb begin
      w_state_nxt = r_state;
      w_rd_lat    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_count != '0) begin
               w_state_nxt = ST_W_ADDR;
            end else if (up_req & ~up_wr) begin
               w_state_nxt = ST_R_ADDR;
               w_rd_lat    = 1'b1;
            end
         end
         ST_W_ADDR: if (mem_addr_ok) w_state_nxt = ST_W_DATA;
         ST_W_DATA: if (mem_data_ok) w_state_nxt = ST_IDLE;
         ST_R_ADDR: if (mem_addr_ok) w_state_nxt = ST_R_DATA;
         ST_R_DATA: if (mem_data_ok) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   assign mem_req   = w_st_wa | w_st_ra;
   assign mem_wr    = w_st_wa;
   assign mem_size  = w_st_wa ? w_head.size :
                      w_st_ra ? r_rd_size   : 2'b00;
   assign mem_addr  = w_st_wa ? w_head.addr :
                      w_st_ra ? r_rd_addr   : '0;
   assign mem_wdata = w_st_wa ? w_head.wdata : '0;

   assign up_addr_ok = w_push | (w_st_ra & mem_addr_ok) | w_fwd;
   assign up_data_ok = r_data_ok | (w_st_rd & mem_data_ok);

   assign wb_empty = w_empty & ~w_st_wa & ~w_st_wd;

endmodule
